multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port ctrl_MULT, input, 1 bit: start a signed multiply, sampled on the rising edge.
REQ-004 SHALL have port ctrl_DIV, input, 1 bit: start a signed divide, sampled on the rising edge.
REQ-005 SHALL have ports data_operandA and data_operandB, input, 32 bits each: two's-complement operands (A*B, A/B).
REQ-006 SHALL have port ir_in, input, 32 bits: instruction word captured with the operands.
REQ-007 SHALL have port data_result, output, 32 bits: product low word or quotient.
REQ-008 SHALL have port data_exception, output, 1 bit: overflow or divide-by-zero flag.
REQ-009 SHALL have port ir_out, output, 32 bits: instruction word of the operation being reported.
REQ-010 SHALL have port data_resultRDY, output, 1 bit: one-cycle completion pulse that drives the downstream latch write enable.
REQ-011 SHALL have port busy, output, 1 bit: iteration in progress; pipeline stall request.

Function
REQ-012 SHALL implement states IDLE, MULT, DIV and DONE; busy SHALL be 1 exactly in MULT and DIV.
REQ-013 SHALL accept a start only in IDLE or DONE; on acceptance it SHALL register both operands and ir_in, and SHALL enter MULT or DIV.
REQ-014 SHALL ignore ctrl_MULT and ctrl_DIV while busy=1, and SHALL ignore a start when both are high in the same cycle.
REQ-015 SHALL iterate one bit per cycle for 32 cycles (shift-add multiply; restoring divide on magnitudes, with sign fixed after).
REQ-016 With the start sampled at edge 0: data_resultRDY SHALL rise after edge 33 and fall after edge 34; state SHALL be DONE during that cycle.
REQ-017 SHALL go from DONE to IDLE unconditionally unless a new start is accepted; back-to-back operations are allowed with no gap cycle.
REQ-018 Multiply: data_result SHALL be the low 32 bits of the 64-bit signed product; data_exception SHALL be 1 when the product is outside [-2^31, 2^31-1].
REQ-019 Divide: quotient SHALL truncate toward zero; -2^31 / -1 SHALL give 0x80000000 with data_exception=1.
REQ-020 Divide by zero SHALL give data_result=0 and data_exception=1.
REQ-021 data_result, data_exception and ir_out SHALL update only on the edge entering DONE, and SHALL hold their values until the next DONE.

Reset
REQ-022 clr=1 SHALL immediately force state IDLE and set data_result, data_exception, ir_out, data_resultRDY and busy to 0, regardless of the clock.
REQ-023 A reset during MULT or DIV SHALL abandon the operation with no data_resultRDY pulse; a start SHALL be accepted on the first edge after clr falls.

Configuration
REQ-024 When macro MULTDIV_DIV0_FAST_EN is defined, a divide with data_operandB=0 SHALL go directly to DONE at edge 1; data_resultRDY SHALL then be high between edges 1 and 2, with result 0 and exception 1.
REQ-025 When MULTDIV_DIV0_FAST_EN is undefined, divide-by-zero SHALL take the full 33-cycle latency with the same result values.

Verification
REQ-026 ctrl_MULT with A=7, B=-3 (0xFFFFFFFD) and ir_in=0x12345678 -> after edge 33: data_result=0xFFFFFFEB, exception=0, ir_out=0x12345678, RDY high for exactly 1 cycle.
REQ-027 ctrl_MULT with A=B=0x00010000 -> data_result=0x00000000, exception=1; A=0x80000000, B=0xFFFFFFFF -> exception=1.
REQ-028 ctrl_DIV with A=-7, B=2 -> data_result=0xFFFFFFFD, exception=0; A=0x80000000, B=-1 -> 0x80000000, exception=1.
REQ-029 ctrl_DIV with A=5, B=0 -> result 0, exception 1; RDY after edge 33 (macro off) or after edge 1 (macro on).
REQ-030 Start MULT, then pulse ctrl_DIV at edge 5 and clr at edge 10 -> DIV ignored, all outputs 0 at once, no RDY pulse, next start completes normally.
REQ-031 A second start asserted during the DONE cycle -> accepted; second RDY arrives 33 edges later with first results held until then.

Source files
------------

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// multdiv_unit : iterative signed 32x32 multiply / divide, one bit per cycle.
// Optional macro MULTDIV_DIV0_FAST_EN: divide-by-zero completes at edge 1.
// Revision: 1.0
// ============================================================================
module multdiv_unit (
  input  logic        clock,
  input  logic        clr,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [31:0] ir_in,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic [31:0] ir_out,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'd32;
`ifdef MULTDIV_DIV0_FAST_EN
  localparam logic FAST_DIV0 = 1'b1;
`else
  localparam logic FAST_DIV0 = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [63:0] work_q, work_d;
  logic [31:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic        div0_q, div0_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic [31:0] ir_out_q, ir_out_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic        can_start, start_mult, start_div;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum, rem_shift, rem_diff;
  logic [63:0] prod_signed;
  logic [31:0] quot_signed;

  always_comb begin
    mag_a       = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    mag_b       = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
    can_start   = (state_q == S_IDLE) || (state_q == S_DONE);
    start_mult  = can_start && ctrl_MULT && !ctrl_DIV;
    start_div   = can_start && ctrl_DIV && !ctrl_MULT;
    add_sum     = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, mag_q} : 33'd0);
    rem_shift   = {work_q[63:32], work_q[31]};
    rem_diff    = rem_shift - {1'b0, mag_q};
    prod_signed = neg_q ? (~work_q + 64'd1) : work_q;
    quot_signed = neg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];

    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    ir_d     = ir_q;
    result_d = result_q;
    exc_d    = exc_q;
    ir_out_d = ir_out_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      S_MULT: begin
        if (cnt_q == LAST_STEP) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          rdy_d    = 1'b1;
          result_d = prod_signed[31:0];
          exc_d    = (prod_signed[63:31] != {33{prod_signed[31]}});
          ir_out_d = ir_q;
        end else begin
          work_d = {add_sum, work_q[31:1]};
          cnt_d  = cnt_q + 6'd1;
        end
      end
      S_DIV: begin
        if ((cnt_q == LAST_STEP) || (FAST_DIV0 && div0_q)) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          rdy_d    = 1'b1;
          result_d = div0_q ? 32'd0 : quot_signed;
          // Only -2^31 / -1 yields a positive magnitude of 2^31.
          exc_d    = div0_q | (!neg_q & work_q[31]);
          ir_out_d = ir_q;
        end else begin
          if (!rem_diff[32]) begin
            work_d = {rem_diff[31:0], work_q[30:0], 1'b1};
          end else begin
            work_d = {rem_shift[31:0], work_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_mult || start_div) begin
      state_d = start_mult ? S_MULT : S_DIV;
      busy_d  = 1'b1;
      cnt_d   = 6'd0;
      neg_d   = data_operandA[31] ^ data_operandB[31];
      div0_d  = start_div && (data_operandB == 32'd0);
      ir_d    = ir_in;
      work_d  = {32'd0, start_mult ? mag_b : mag_a};
      mag_d   = start_mult ? mag_a : mag_b;
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      work_q   <= 64'd0;
      mag_q    <= 32'd0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ir_q     <= 32'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      ir_out_q <= 32'd0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ir_q     <= ir_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      ir_out_q <= ir_out_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign ir_out         = ir_out_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// Directed testbench for multdiv_unit: multiply, divide, reset abort, back-to-back.
module tb_multdiv_unit;

  logic        clock;
  logic        clr;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] ir_in;
  logic [31:0] data_result;
  logic        data_exception;
  logic [31:0] ir_out;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef MULTDIV_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  multdiv_unit dut (
    .clock          (clock),
    .clr            (clr),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ir_in          (ir_in),
    .data_result    (data_result),
    .data_exception (data_exception),
    .ir_out         (ir_out),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a start so it is sampled at the next rising edge (edge 0).
  task automatic start_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ir);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = !m;
    data_operandA = a; data_operandB = b; ir_in = ir;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
  endtask

  // Count rising edges until RDY is seen; -1 if it never arrives.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic run_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ir, output int lat, output logic [31:0] res,
                        output logic exc, output logic [31:0] irq, output logic rdy_after);
    start_op(m, a, b, ir);
    wait_rdy(lat);
    res = data_result; exc = data_exception; irq = ir_out;
    @(posedge clock); #1;
    rdy_after = data_resultRDY;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    #2 clr = 1'b1;
    #1;
    checks++; if (data_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b expected 0", data_exception); end
    checks++; if (ir_out !== 32'd0) begin errors++; $display("FAIL reset_ir: got %h expected 0", ir_out); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    clr = 1'b0;
  endtask

  task automatic run_table(input logic m, input int n, input logic [31:0] va [6],
                           input logic [31:0] vb [6], input logic [31:0] vr [6],
                           input logic ve [6], input int vl [6], input string tag);
    int lat; logic [31:0] res; logic exc; logic [31:0] irq; logic ra;
    for (int i = 0; i < n; i++) begin
      run_op(m, va[i], vb[i], 32'h1234_5670 + i, lat, res, exc, irq, ra);
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL %s%0d latency: got %0d expected %0d", tag, i, lat, vl[i]); end
      checks++; if (res !== vr[i]) begin errors++; $display("FAIL %s%0d result: got %h expected %h", tag, i, res, vr[i]); end
      checks++; if (exc !== ve[i]) begin errors++; $display("FAIL %s%0d exception: got %b expected %b", tag, i, exc, ve[i]); end
      checks++; if (irq !== 32'h1234_5670 + i) begin errors++; $display("FAIL %s%0d ir_out: got %h expected %h", tag, i, irq, 32'h1234_5670 + i); end
      checks++; if (ra !== 1'b0) begin errors++; $display("FAIL %s%0d rdy_width: got %b expected 0", tag, i, ra); end
    end
  endtask

  task automatic test_mult();
    logic [31:0] va [6] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
    logic [31:0] vb [6] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd1, 32'd0};
    logic [31:0] vr [6] = '{32'hFFFF_FFEB, 32'd0, 32'h8000_0000, 32'd30, 32'h8000_0000, 32'd0};
    logic        ve [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int          vl [6] = '{33, 33, 33, 33, 33, 33};
    run_table(1'b1, 5, va, vb, vr, ve, vl, "mult");
  endtask

  task automatic test_div();
    logic [31:0] va [6] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd7, 32'h8000_0000, 32'd5};
    logic [31:0] vb [6] = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'd2, 32'd0};
    logic [31:0] vr [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd14, 32'hFFFF_FFFD, 32'hC000_0000, 32'd0};
    logic        ve [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int          vl [6] = '{33, 33, 33, 33, 33, DIV0_LAT};
    run_table(1'b0, 6, va, vb, vr, ve, vl, "div");
  endtask

  task automatic test_both_high();
    @(negedge clock);
    ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_high_busy: got %b expected 0", busy); end
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat; logic seen_rdy;
    seen_rdy = 1'b0;
    start_op(1'b1, 32'd9, 32'd9, 32'hAAAA_0001);      // edge 0
    repeat (4) @(posedge clock);                      // edge 4
    @(negedge clock); ctrl_DIV = 1'b1; data_operandB = 32'd1;
    @(posedge clock);                                 // edge 5
    @(negedge clock); ctrl_DIV = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;                           // edges 6..9
      if (data_resultRDY) seen_rdy = 1'b1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    #2 clr = 1'b1;
    #1;
    checks++; if (data_result !== 32'd0) begin errors++; $display("FAIL abort_result: got %h expected 0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL abort_exc: got %b expected 0", data_exception); end
    checks++; if (ir_out !== 32'd0) begin errors++; $display("FAIL abort_ir: got %h expected 0", ir_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    @(posedge clock); #1;
    if (data_resultRDY) seen_rdy = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'hFFFF_FFFC; ir_in = 32'hBEEF_0002;
    @(posedge clock);
    @(negedge clock); ctrl_MULT = 1'b0;
    checks++; if (seen_rdy !== 1'b0) begin errors++; $display("FAIL abort_no_rdy: got %b expected 0", seen_rdy); end
    wait_rdy(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL abort_restart_latency: got %0d expected 33", lat); end
    checks++; if (data_result !== 32'hFFFF_FFF4) begin errors++; $display("FAIL abort_restart_result: got %h expected fffffff4", data_result); end
    checks++; if (ir_out !== 32'hBEEF_0002) begin errors++; $display("FAIL abort_restart_ir: got %h expected beef0002", ir_out); end
  endtask

  task automatic test_back_to_back();
    int lat; logic held;
    held = 1'b1;
    start_op(1'b1, 32'd7, 32'hFFFF_FFFD, 32'h1111_1111);
    wait_rdy(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", lat); end
    start_op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h2222_2222);   // accepted in DONE
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL b2b_rdy_fall: got %b expected 0", data_resultRDY); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    lat = -1;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin lat = e; break; end
      if (data_result !== 32'hFFFF_FFEB || ir_out !== 32'h1111_1111) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %b expected 1", held); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
    checks++; if (data_result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_second_result: got %h expected fffffffd", data_result); end
    checks++; if (ir_out !== 32'h2222_2222) begin errors++; $display("FAIL b2b_second_ir: got %h expected 22222222", ir_out); end
    @(posedge clock); #1;
  endtask

  initial begin
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0; ir_in = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_both_high();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
